collision_check: RTL and testbench

Reads the board RAM at the four cells a candidate tetromino would occupy and reports whether any cell is occupied or off the board. The piece-movement FSM issues one check before committing a move or rotation. The block shares the board RAM read port with the renderer, and uses the codebase's piece offset table and coordinate-to-address mapping. It is read-only and never drives write enable.

---
 rtl/collision_check_pkg.sv | 87 ++++++++
 rtl/collision_check_cell_bounds.sv | 33 +++
 rtl/collision_check.sv | 182 ++++++++++++++++++
 tb/tb_collision_check.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/collision_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collision_check_pkg
// Description : Shared definitions for the collision checker: FSM state
//               encoding, default board dimensions, the piece type
//               enumeration, the piece offset table and the board
//               coordinate-to-address mapping.
// Contents    : c_ST_* state constants, c_BOARD_W_DEF / c_BOARD_H_DEF,
//               piece_e, piece_offsets_t, piece_offsets(), coord_to_addr()
// Revision    : 1.0 - initial release
// ============================================================================
package collision_check_pkg;

  // Board dimension defaults (cells)
  localparam int unsigned c_BOARD_W_DEF = 10;
  localparam int unsigned c_BOARD_H_DEF = 24;

  // FSM state encoding
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_ADDR   = 3'd1;
  localparam logic [2:0] c_ST_WAIT   = 3'd2;
  localparam logic [2:0] c_ST_SAMPLE = 3'd3;
  localparam logic [2:0] c_ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    PIECE_I    = 3'd0,
    PIECE_O    = 3'd1,
    PIECE_T    = 3'd2,
    PIECE_S    = 3'd3,
    PIECE_Z    = 3'd4,
    PIECE_J    = 3'd5,
    PIECE_L    = 3'd6,
    PIECE_NONE = 3'd7
  } piece_e;

  // Cell k of a piece lives in bits [2k+1:2k] of each field.
  typedef struct packed {
    logic [7:0] x_offsets;
    logic [7:0] y_offsets;
  } piece_offsets_t;

  // Offset table. Shapes are given for rotation 0 inside a 4x4 box;
  // each rotation step maps (x,y) -> (3-y, x), which keeps every offset
  // in the unsigned 0..3 range.
  function automatic piece_offsets_t piece_offsets(input piece_e p, input logic [1:0] rot);
    piece_offsets_t res;
    logic [7:0] bx;
    logic [7:0] by;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] t;
    case (p)
      PIECE_I: begin bx = {2'd3, 2'd2, 2'd1, 2'd0}; by = {2'd0, 2'd0, 2'd0, 2'd0}; end
      PIECE_T: begin bx = {2'd1, 2'd2, 2'd1, 2'd0}; by = {2'd1, 2'd0, 2'd0, 2'd0}; end
      PIECE_S: begin bx = {2'd1, 2'd0, 2'd2, 2'd1}; by = {2'd1, 2'd1, 2'd0, 2'd0}; end
      PIECE_Z: begin bx = {2'd2, 2'd1, 2'd1, 2'd0}; by = {2'd1, 2'd1, 2'd0, 2'd0}; end
      PIECE_J: begin bx = {2'd2, 2'd1, 2'd0, 2'd0}; by = {2'd1, 2'd1, 2'd1, 2'd0}; end
      PIECE_L: begin bx = {2'd2, 2'd1, 2'd0, 2'd2}; by = {2'd1, 2'd1, 2'd1, 2'd0}; end
      default: begin bx = {2'd1, 2'd0, 2'd1, 2'd0}; by = {2'd1, 2'd1, 2'd0, 2'd0}; end
    endcase
    res = '0;
    for (int k = 0; k < 4; k++) begin
      x = bx[2*k +: 2];
      y = by[2*k +: 2];
      for (int r = 1; r < 4; r++) begin
        if (r <= int'(rot)) begin
          t = x;
          x = 2'd3 - y;
          y = t;
        end
      end
      res.x_offsets[2*k +: 2] = x;
      res.y_offsets[2*k +: 2] = y;
    end
    return res;
  endfunction

  // Row-major board address: y * width + x.
  function automatic logic [7:0] coord_to_addr(input logic [5:0] cx, input logic [6:0] cy,
                                               input int unsigned board_w);
    logic [15:0] a;
    a = 16'(cy) * 16'(board_w) + 16'(cx);
    return a[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/collision_check_cell_bounds.sv
`default_nettype none
// ============================================================================
// Module      : cell_bounds
// Description : Combinational cell coordinate and bounds check. Adds a 2-bit
//               offset to the anchor with a widened result so that sums past
//               the field range never wrap back onto the board.
// Ports       : x_anc[4:0], y_anc[5:0]  anchor coordinates
//               xoff[1:0],  yoff[1:0]   cell offsets
//               cx[5:0], cy[6:0]        cell coordinates
//               oob                     cell lies off the board
// Revision    : 1.0 - initial release
// ============================================================================
module cell_bounds
  import collision_check_pkg::*;
#(
  parameter int unsigned BOARD_W = c_BOARD_W_DEF,
  parameter int unsigned BOARD_H = c_BOARD_H_DEF
) (
  input  logic [4:0] x_anc,
  input  logic [5:0] y_anc,
  input  logic [1:0] xoff,
  input  logic [1:0] yoff,
  output logic [5:0] cx,
  output logic [6:0] cy,
  output logic       oob
);

  assign cx  = {1'b0, x_anc} + {4'b0000, xoff};
  assign cy  = {1'b0, y_anc} + {5'b00000, yoff};
  assign oob = (32'(cx) >= BOARD_W) || (32'(cy) >= BOARD_H);

endmodule
`default_nettype wire

// File: rtl/collision_check.sv
`default_nettype none
// ============================================================================
// Module      : collision_check
// Description : Reads the board RAM at the four cells a candidate tetromino
//               would occupy and reports whether any cell is occupied or off
//               the board. Read-only user of the shared board RAM port.
// Ports       : clk, resetn          clock, async active-low reset
//               start                request, honoured only when idle
//               x_anc, y_anc         candidate anchor
//               block, rotation      piece type and rotation
//               ram_q                board RAM read data (0 = empty)
//               ram_addr             registered board RAM read address
//               busy, done           status; done is a one-cycle pulse
//               collision            result, held until the next start
// Options     : EARLY_EXIT_EN - stop at the first hit or off-board cell
// Revision    : 1.0 - initial release
// ============================================================================
module collision_check
  import collision_check_pkg::*;
#(
  parameter int unsigned BOARD_W  = c_BOARD_W_DEF,
  parameter int unsigned BOARD_H  = c_BOARD_H_DEF,
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [4:0] x_anc,
  input  logic [5:0] y_anc,
  input  logic [2:0] block,
  input  logic [1:0] rotation,
  input  logic [5:0] ram_q,
  output logic [7:0] ram_addr,
  output logic       busy,
  output logic       done,
  output logic       collision
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [2:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [4:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic [2:0]       blk_q, blk_d;
  logic [1:0]       rot_q, rot_d;
  logic             coll_q, coll_d;
  logic             oob_q, oob_d;
  logic [7:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  piece_offsets_t   w_offs;
  logic [1:0]       w_xoff;
  logic [1:0]       w_yoff;
  logic [5:0]       w_cx;
  logic [6:0]       w_cy;
  logic             w_oob;
  logic             w_hit;

  // Offsets of the current cell, taken from the latched piece.
  assign w_offs = piece_offsets(piece_e'(blk_q), rot_q);
  assign w_xoff = w_offs.x_offsets[{idx_q, 1'b0} +: 2];
  assign w_yoff = w_offs.y_offsets[{idx_q, 1'b0} +: 2];

  cell_bounds #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_cell_bounds (
    .x_anc (x_q),
    .y_anc (y_q),
    .xoff  (w_xoff),
    .yoff  (w_yoff),
    .cx    (w_cx),
    .cy    (w_cy),
    .oob   (w_oob)
  );

  // An off-board cell counts as a hit whatever the RAM returns.
  assign w_hit = oob_q | (ram_q != 6'd0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    blk_d   = blk_q;
    rot_d   = rot_q;
    coll_d  = coll_q;
    oob_d   = oob_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start) begin
          x_d     = x_anc;
          y_d     = y_anc;
          blk_d   = block;
          rot_d   = rotation;
          coll_d  = 1'b0;
          idx_d   = 2'd0;
          state_d = c_ST_ADDR;
        end
      end
      c_ST_ADDR: begin
        oob_d  = w_oob;
        // Off-board cells park the address at 0 rather than alias a real cell.
        addr_d = w_oob ? 8'd0 : coord_to_addr(w_cx, w_cy, BOARD_W);
        cnt_d  = CNT_W'(READ_LAT - 1);
`ifdef EARLY_EXIT_EN
        if (w_oob) begin
          coll_d  = 1'b1;
          state_d = c_ST_DONE;
        end else begin
          state_d = c_ST_WAIT;
        end
`else
        state_d = c_ST_WAIT;
`endif
      end
      c_ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = c_ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      c_ST_SAMPLE: begin
        coll_d = coll_q | w_hit;
        if (idx_q == 2'd3) begin
          state_d = c_ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = c_ST_ADDR;
        end
`ifdef EARLY_EXIT_EN
        if (w_hit) begin
          state_d = c_ST_DONE;
        end
`endif
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= c_ST_IDLE;
      idx_q   <= 2'd0;
      x_q     <= 5'd0;
      y_q     <= 6'd0;
      blk_q   <= 3'd0;
      rot_q   <= 2'd0;
      coll_q  <= 1'b0;
      oob_q   <= 1'b0;
      addr_q  <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blk_q   <= blk_d;
      rot_q   <= rot_d;
      coll_q  <= coll_d;
      oob_q   <= oob_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != c_ST_IDLE);
  assign done      = (state_q == c_ST_DONE);
  assign collision = coll_q;
  assign ram_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_check
// Description : Directed self-checking bench for collision_check with a
//               one-cycle registered board RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_check;
  import collision_check_pkg::*;

`ifdef EARLY_EXIT_EN
  localparam int c_DONE_HIT  = 7;
  localparam int c_DONE_XOOB = 5;
  localparam int c_DONE_YOOB = 2;
`else
  localparam int c_DONE_HIT  = 13;
  localparam int c_DONE_XOOB = 13;
  localparam int c_DONE_YOOB = 13;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [4:0] x_anc = '0;
  logic [5:0] y_anc = '0;
  logic [2:0] block = '0;
  logic [1:0] rotation = '0;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic       busy;
  logic       done;
  logic       collision;

  logic [5:0] mem [0:255];
  logic [5:0] ram_rd = 6'd0;
  logic       force_q = 1'b0;
  logic [7:0] addr_log [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_rd <= mem[ram_addr];
  assign ram_q = force_q ? 6'h3F : ram_rd;

  collision_check dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .x_anc     (x_anc),
    .y_anc     (y_anc),
    .block     (block),
    .rotation  (rotation),
    .ram_q     (ram_q),
    .ram_addr  (ram_addr),
    .busy      (busy),
    .done      (done),
    .collision (collision)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one start in cycle 0 and follows the check until done (or abort).
  // restart_cyc : cycle in which a second start with other inputs is pulsed
  // force_cell  : cell index during which ram_q is forced to 0x3F
  // abort_cyc   : cycle in which resetn is pulled low
  task automatic run_check(input logic [4:0] x, input logic [5:0] y,
                           input logic [2:0] b, input logic [1:0] r,
                           input int restart_cyc, input int force_cell, input int abort_cyc,
                           output int dcyc, output logic coll);
    logic busy_ok;
    busy_ok = 1'b1;
    dcyc = -1;
    coll = 1'bx;
    for (int i = 0; i < 4; i++) addr_log[i] = 8'hEE;
    @(negedge clk);
    x_anc = x; y_anc = y; block = b; rotation = r; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        x_anc = 5'd9; y_anc = 6'd63; block = 3'(PIECE_T); rotation = 2'd2;
      end
      force_q = (force_cell >= 0) && (c >= 1 + 3*force_cell) && (c <= 3 + 3*force_cell);
      if (c >= 2 && c <= 11 && ((c - 2) % 3 == 0)) addr_log[(c-2)/3] = ram_addr;
      if (c == abort_cyc) begin
        resetn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_collision", 32'(collision), 32'd0);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        dcyc = c;
        coll = collision;
        break;
      end
    end
    force_q = 1'b0;
    start = 1'b0;
    if (abort_cyc < 0) chk("busy_until_done", 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int   d;
    logic co;
    logic quiet;
    for (int i = 0; i < 256; i++) mem[i] = 6'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    resetn = 1'b1;

    // Empty board, I piece at (3,5): cells (3..6,5) -> addresses 53..56
    run_check(5'd3, 6'd5, 3'(PIECE_I), 2'd0, -1, -1, -1, d, co);
    chk("empty_done_cycle", 32'(d), 32'd13);
    chk("empty_collision", 32'(co), 32'd0);
    chk("empty_addr0", 32'(addr_log[0]), 32'd53);
    chk("empty_addr1", 32'(addr_log[1]), 32'd54);
    chk("empty_addr2", 32'(addr_log[2]), 32'd55);
    chk("empty_addr3", 32'(addr_log[3]), 32'd56);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // T piece, rotation 1, anchor (0,0): cells (3,0),(3,1),(3,2),(2,1)
    run_check(5'd0, 6'd0, 3'(PIECE_T), 2'd1, -1, -1, -1, d, co);
    chk("trot1_done_cycle", 32'(d), 32'd13);
    chk("trot1_addr0", 32'(addr_log[0]), 32'd3);
    chk("trot1_addr1", 32'(addr_log[1]), 32'd13);
    chk("trot1_addr2", 32'(addr_log[2]), 32'd23);
    chk("trot1_addr3", 32'(addr_log[3]), 32'd12);

    // Occupied cell (4,5) covered by the I piece from (3,5)
    mem[54] = 6'd1;
    run_check(5'd3, 6'd5, 3'(PIECE_I), 2'd0, -1, -1, -1, d, co);
    chk("hit_done_cycle", 32'(d), 32'(c_DONE_HIT));
    chk("hit_collision", 32'(co), 32'd1);
    repeat (3) @(negedge clk);
    chk("hit_held", 32'(collision), 32'd1);

    // New start clears the held result: O piece at (0,0) on empty cells 0,1,10,11
    run_check(5'd0, 6'd0, 3'(PIECE_O), 2'd0, -1, -1, -1, d, co);
    chk("clear_done_cycle", 32'(d), 32'd13);
    chk("clear_collision", 32'(co), 32'd0);
    chk("o_addr2", 32'(addr_log[2]), 32'd10);
    chk("o_addr3", 32'(addr_log[3]), 32'd11);

    // x_anc=9: cell 1 at cx=10 is off-board, ram_q forced to 0x3F during it
    run_check(5'd9, 6'd5, 3'(PIECE_I), 2'd0, -1, 1, -1, d, co);
    chk("xoob_done_cycle", 32'(d), 32'(c_DONE_XOOB));
    chk("xoob_collision", 32'(co), 32'd1);
    chk("xoob_addr0", 32'(addr_log[0]), 32'd59);
`ifndef EARLY_EXIT_EN
    chk("xoob_addr1", 32'(addr_log[1]), 32'd0);
    chk("xoob_addr3", 32'(addr_log[3]), 32'd0);
`endif

    // y_anc=63, I piece rotation 1 (yoff 0..3): cy up to 66, never wraps to 0..2
    run_check(5'd0, 6'd63, 3'(PIECE_I), 2'd1, -1, -1, -1, d, co);
    chk("yoob_done_cycle", 32'(d), 32'(c_DONE_YOOB));
    chk("yoob_collision", 32'(co), 32'd1);
    chk("yoob_addr0", 32'(addr_log[0]), 32'd0);
`ifndef EARLY_EXIT_EN
    chk("yoob_addr1", 32'(addr_log[1]), 32'd0);
    chk("yoob_addr2", 32'(addr_log[2]), 32'd0);
    chk("yoob_addr3", 32'(addr_log[3]), 32'd0);
`endif

    // Second start in cycle 5 with off-board inputs is ignored
    mem[54] = 6'd0;
    run_check(5'd3, 6'd5, 3'(PIECE_I), 2'd0, 5, -1, -1, d, co);
    chk("restart_done_cycle", 32'(d), 32'd13);
    chk("restart_collision", 32'(co), 32'd0);
    chk("restart_addr3", 32'(addr_log[3]), 32'd56);

    // Reset in cycle 7 abandons the check with no done
    run_check(5'd3, 6'd5, 3'(PIECE_I), 2'd0, -1, -1, 7, d, co);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    chk("abort_no_done", 32'(quiet), 32'd1);

    // Normal check after reset release
    run_check(5'd0, 6'd0, 3'(PIECE_O), 2'd0, -1, -1, -1, d, co);
    chk("post_abort_done_cycle", 32'(d), 32'd13);
    chk("post_abort_collision", 32'(co), 32'd0);
    chk("post_abort_addr1", 32'(addr_log[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
